// File: rtl/jelly2_img_to_axi4s_buffered.sv
// Image-pipeline stream to AXI4-Stream video with a first-word-fall-through FIFO and upstream cke throttling.
// Define JELLY2_IMG_TO_AXI4S_BUFFERED_OVERFLOW_DETECT_EN to build the sticky overflow detector.
module jelly2_img_to_axi4s_buffered #(
  parameter  int unsigned TUSER_WIDTH    = 1,
  parameter  int unsigned TDATA_WIDTH    = 8,
  parameter  int unsigned FIFO_PTR_WIDTH = 5,
  parameter  int unsigned CKE_MARGIN     = 8,
  localparam int unsigned USER_WIDTH     = (TUSER_WIDTH > 1) ? TUSER_WIDTH - 1 : 1
) (
  input  logic                      reset,
  input  logic                      clk,
  input  logic                      aclken,
  output logic                      img_cke,
  input  logic                      s_img_row_first,
  input  logic                      s_img_row_last,
  input  logic                      s_img_col_first,
  input  logic                      s_img_col_last,
  input  logic                      s_img_de,
  input  logic [USER_WIDTH-1:0]     s_img_user,
  input  logic [TDATA_WIDTH-1:0]    s_img_data,
  input  logic                      s_img_valid,
  output logic [TUSER_WIDTH-1:0]    m_axi4s_tuser,
  output logic                      m_axi4s_tlast,
  output logic [TDATA_WIDTH-1:0]    m_axi4s_tdata,
  output logic                      m_axi4s_tvalid,
  input  logic                      m_axi4s_tready,
  output logic [FIFO_PTR_WIDTH:0]   fifo_count,
  output logic                      overflow
);

  localparam int unsigned DEPTH = 2 ** FIFO_PTR_WIDTH;
  localparam int unsigned CW    = FIFO_PTR_WIDTH + 1;
  localparam int unsigned EW    = TDATA_WIDTH + TUSER_WIDTH + 1;

  logic [EW-1:0]             mem_q [DEPTH];
  logic [FIFO_PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]             count_q, count_d;
  logic                      stall_q, stall_d;

  logic [TUSER_WIDTH-1:0]    wr_tuser_c;
  logic [EW-1:0]             wr_entry_c;
  logic                      wr_req_c;
  logic                      wr_en_c;
  logic                      rd_en_c;
  logic                      full_c;
  logic                      unused_c;

  // row_last carries no AXI4S meaning; user bits are dropped when tuser is frame-start only
  assign unused_c = ^{s_img_row_last, s_img_user};

  generate
    if (TUSER_WIDTH > 1) begin : g_user
      assign wr_tuser_c = {s_img_user, s_img_row_first & s_img_col_first};
    end else begin : g_no_user
      assign wr_tuser_c = s_img_row_first & s_img_col_first;
    end
  endgenerate

  assign wr_entry_c = {s_img_col_last, wr_tuser_c, s_img_data};

  // Head of FIFO falls through; outputs read as zero while empty
  assign m_axi4s_tvalid = (count_q != '0);
  assign {m_axi4s_tlast, m_axi4s_tuser, m_axi4s_tdata} = m_axi4s_tvalid ? mem_q[rd_ptr_q] : EW'(0);
  assign fifo_count     = count_q;
  assign img_cke        = aclken & ~stall_q & ~reset;

  always_comb begin
    full_c   = (count_q == CW'(DEPTH));
    wr_req_c = aclken & s_img_valid & s_img_de;
    rd_en_c  = aclken & m_axi4s_tvalid & m_axi4s_tready;
    // a write at full survives only if the head leaves in the same cycle
    wr_en_c  = wr_req_c & (~full_c | rd_en_c);
    wr_ptr_d = wr_ptr_q + FIFO_PTR_WIDTH'(wr_en_c);
    rd_ptr_d = rd_ptr_q + FIFO_PTR_WIDTH'(rd_en_c);
    count_d  = count_q;
    if (wr_en_c && !rd_en_c) begin
      count_d = count_q + CW'(1);
    end else if (!wr_en_c && rd_en_c) begin
      count_d = count_q - CW'(1);
    end
    stall_d = stall_q;
    if (aclken) begin
      stall_d = (CW'(DEPTH) - count_d) < CW'(CKE_MARGIN);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
    end
  end

  // Storage needs no reset: reads are masked by the count
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_q[wr_ptr_q] <= wr_entry_c;
    end
  end

`ifdef JELLY2_IMG_TO_AXI4S_BUFFERED_OVERFLOW_DETECT_EN
  logic overflow_q, overflow_d;

  assign overflow_d = overflow_q | (wr_req_c & ~wr_en_c);
  assign overflow   = overflow_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end
`else
  assign overflow = 1'b0;
`endif

endmodule
